// File: rtl/ram.sv
// Single-port synchronous RAM with registered read data and write-through.
// Asynchronous active-low reset clears both the storage array and the output register.
module ram #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  // A write cycle presents the incoming word instead of the stale stored one.
  always_comb begin
    data_d = mem_q[address];
    if (write_enable) begin
      data_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_q <= '0;
    end else begin
      if (write_enable) begin
        mem_q[address] <= data_in;
      end
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: expected words are queued when a cycle is driven
// and compared one edge later, when the registered output appears.
module tb_ram;

  logic       clk;
  logic       rst_n;
  logic       write_enable;
  logic [3:0] address;
  logic [3:0] data_in;
  logic [3:0] data_out;

  logic [3:0] model [16];
  logic [3:0] expQ [$];
  int         checks;
  int         errors;

  ram #(
    .DATA_WIDTH(4),
    .ADDR_WIDTH(4),
    .DEPTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .write_enable(write_enable),
    .address(address),
    .data_in(data_in),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] actual,
                             input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) begin
      model[i] = 4'h0;
    end
  endtask

  // Drive one cycle on the falling edge, predict the output, then check it after the rising edge.
  task automatic applyStimulus(input string tag, input logic we, input logic [3:0] addr,
                               input logic [3:0] din);
    logic [3:0] expected;
    @(negedge clk);
    write_enable = we;
    address      = addr;
    data_in      = din;
    if (we) begin
      expected    = din;
      model[addr] = din;
    end else begin
      expected = model[addr];
    end
    expQ.push_back(expected);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, data_out, ~data_out);
    end else begin
      checkOutput(tag, data_out, expQ.pop_front());
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    write_enable = 1'b0;
    address      = 4'h0;
    data_in      = 4'h0;
    clearModel();

    // Writes attempted while reset is held must be dropped.
    @(negedge clk);
    write_enable = 1'b1;
    address      = 4'h2;
    data_in      = 4'h5;
    @(posedge clk);
    #1;
    checkOutput("rst_hold", data_out, 4'h0);
    @(negedge clk);
    write_enable = 1'b0;
    rst_n        = 1'b1;

    for (int a = 0; a < 16; a++) begin
      applyStimulus("rst_read", 1'b0, 4'(a), 4'h0);
    end

    applyStimulus("wr3_thru", 1'b1, 4'h3, 4'h9);
    applyStimulus("wr7_thru", 1'b1, 4'h7, 4'hC);
    applyStimulus("rd3", 1'b0, 4'h3, 4'h0);
    applyStimulus("rd7", 1'b0, 4'h7, 4'h0);
    applyStimulus("rd5_unwritten", 1'b0, 4'h5, 4'h0);
    applyStimulus("rd2_rst_write_lost", 1'b0, 4'h2, 4'h0);

    for (int r = 0; r < 3; r++) begin
      applyStimulus("rd7_repeat", 1'b0, 4'h7, 4'h0);
    end

    applyStimulus("ovr3_thru", 1'b1, 4'h3, 4'hA);
    applyStimulus("ovr3_rd", 1'b0, 4'h3, 4'h0);

    for (int a = 0; a < 16; a++) begin
      applyStimulus("fill_thru", 1'b1, 4'(a), 4'(a) ^ 4'hF);
    end
    for (int a = 0; a < 16; a++) begin
      applyStimulus("fill_rd", 1'b0, 4'(a), 4'h0);
    end

    // Reset asserted between edges must clear the output without a clock.
    applyStimulus("wr7_pre_rst", 1'b1, 4'h7, 4'hC);
    write_enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out", data_out, 4'h0);
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("rd7_post_rst", 1'b0, 4'h7, 4'h0);
    applyStimulus("rd0_post_rst", 1'b0, 4'h0, 4'h0);
    applyStimulus("rd15_post_rst", 1'b0, 4'hF, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
